dmem_sram_slave: RTL and testbench
==================================

# dmem_sram_slave

Responder for the CPU's data-side SRAM-like bus. It accepts load/store requests from the MEM stage (`req`/`wr`/`size`/`addr`/`wdata`) and handshakes with `addr_ok`/`data_ok`. Each request completes in order after a fixed, parameterised latency against an internal word-addressed memory array. It is used as the data memory in core-level simulation and as the reference responder when verifying the pipeline's busy/ok stall logic.

## Interface
Parameters:
- `ADDR_W`, 10: word-index width of the internal array (2^ADDR_W words).
- `LATENCY`, 2: cycles from request acceptance to `data_ok`. Legal range 1..8.
- `QDEPTH`, 2: maximum number of outstanding requests. Legal range 2..4.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `data_req`, in, 1: request valid.
- `data_wr`, in, 1: 1 = store, 0 = load.
- `data_size`, in, 2: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- `data_addr`, in, 32: byte address.
- `data_wdata`, in, 32: store data, already placed in its byte lanes.
- `data_addr_ok`, out, 1: request accepted in this cycle if `data_req` is also 1.
- `data_data_ok`, out, 1: one-cycle completion pulse for the oldest outstanding request.
- `data_rdata`, out, 32: full load word. Valid only while `data_data_ok` is 1 for a load; 0 otherwise.
- `data_err`, out, 1: high together with `data_data_ok` when the completing request was misaligned or had an illegal size.

## Operation
- **Acceptance:** a request is accepted when `data_req & data_addr_ok` is high at a rising edge.
  - `data_addr_ok` = (outstanding count < QDEPTH).
  - It depends only on registered count, not on a completion in the same cycle.
- **Pending queue:** a circular FIFO of QDEPTH entries.
  - Each entry holds: wr, size, addr[ADDR_W+1:0], wdata, countdown[3:0].
  - On accept, the entry's countdown is loaded with LATENCY-1.
- **Countdown:** every valid entry decrements its countdown each cycle, saturating at 0.
- **Completion:** `data_data_ok` = head valid & head countdown == 0.
  - The head pops at the end of that cycle. Completion is strictly in order.
- **Simultaneous accept and pop:** count stays unchanged; the write pointer and read pointer both advance (both wrap modulo QDEPTH).
- **Addressing:** word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias modulo 2^(ADDR_W+2) bytes.
- **Byte strobe:**
  - Byte: strobe = 1 << addr[1:0].
  - Halfword: strobe = addr[1] ? 1100 : 0011.
  - Word: strobe = 1111.
- **Misaligned/illegal requests:** halfword with addr[0]=1, word with addr[1:0]≠0, or size 3.
  - Strobe is forced to 0000, `data_err`=1 at completion, `data_rdata`=0.
- **Stores:** the array is written with the strobed lanes of wdata at the rising edge ending the store's `data_data_ok` cycle.
- **Loads:** `data_rdata` = combinational read of array[head word index] during `data_data_ok`.
  - Any older store to the same word has already been written, so read-after-write in queue order is exact.
- **Reset:**
  - Clears the queue, pointers and count.
  - Outputs after reset: `data_addr_ok`=1, `data_data_ok`=0, `data_rdata`=0, `data_err`=0.
  - Array contents are not cleared.
  - Reset mid-operation drops every pending entry with no write and no `data_data_ok`.

## Timing
- A request accepted at the edge ending cycle T gets `data_data_ok` in cycle T+LATENCY.
- Throughput is one request per cycle when QDEPTH > LATENCY; otherwise `data_addr_ok` drops after QDEPTH accepts until the first pop.
- `data_addr_ok` and `data_data_ok` are functions of registered state only; neither has a combinational path from `data_req`.
- `data_data_ok` never stays high for two cycles for the same entry; consecutive pulses belong to consecutive entries.
- The `rst` edge has priority over accept and pop in the same cycle.

## Test plan
- **Word store then load:** LATENCY=2. Store addr 0x10, wdata 0xDEADBEEF, size 2, accepted at T → `data_data_ok` at T+2, err=0. Load 0x10 → `data_rdata`=0xDEADBEEF with `data_data_ok`.
- **Byte and halfword lanes:**
  - After the word above, store byte 0xAA at 0x11 (wdata 0x0000AA00), then halfword 0x1234 at 0x12 (wdata 0x12340000).
  - Load 0x10 → 0x1234AAEF.
- **Back-to-back throughput:** LATENCY=1, QDEPTH=2. Hold `data_req` for 8 loads → `data_addr_ok` stays 1 and `data_data_ok` is high for 8 consecutive cycles, in order. A store followed immediately by a load to the same word returns the new data.
- **Full queue:** LATENCY=4, QDEPTH=2. Accept 2 requests at T and T+1 → `data_addr_ok`=0 in cycles T+2..T+4, back to 1 in T+5. A held `data_req` is accepted at T+5 and completes at T+9.
- **Misaligned:** word store to 0x22 → `data_data_ok` and `data_err` both 1, array unchanged (a later load of 0x20 returns the old value). Size 3 load → err=1, `data_rdata`=0.
- **Reset mid-operation:**
  - Setup: accept a store of 0x55555555 to 0x40 whose memory word holds 0x11111111.
  - Stimulus: assert `rst` one cycle before its completion.
  - Response: no `data_data_ok`, and all outputs return to their reset values.
  - Check: a later load of 0x40 returns 0x11111111.

Source files
------------

// File: rtl/dmem_sram_slave.sv
// Data-side SRAM-like bus responder.
// Accepts load/store requests into an in-order pending queue; each entry
// completes a fixed LATENCY cycles after acceptance against an internal
// word-addressed array. Stores write their byte lanes at the end of their
// completion cycle, loads read the array combinationally while completing.
//
// Handshake: a request transfers on a rising edge where data_req and
// data_addr_ok are both 1. data_addr_ok depends only on the registered
// outstanding count (never on data_req or a same-cycle completion).
// data_data_ok is a one-cycle pulse per entry, strictly in acceptance order.
module dmem_sram_slave #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        data_err
);

  localparam int PTR_W = (QDEPTH > 2) ? 2 : 1;
  localparam int SLOTS = 1 << PTR_W;
  localparam int CNT_W = 3;
  localparam logic [3:0] CD_INIT = 4'(LATENCY - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QDEPTH);

  // Pending queue storage; only slots 0..QDEPTH-1 are ever addressed.
  logic              q_valid [SLOTS];
  logic              q_wr    [SLOTS];
  logic [1:0]        q_size  [SLOTS];
  logic [ADDR_W+1:0] q_addr  [SLOTS];
  logic [31:0]       q_wdata [SLOTS];
  logic [3:0]        q_cd    [SLOTS];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0] mem [2**ADDR_W];

  logic              accept;
  logic              head_wr;
  logic [1:0]        head_size;
  logic [ADDR_W+1:0] head_addr;
  logic [ADDR_W-1:0] head_idx;
  logic [3:0]        head_strb;
  logic              head_bad;

  // Upper address bits alias and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_addr[31:ADDR_W+2];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign data_addr_ok = (count < CNT_MAX);
  assign accept       = data_req & data_addr_ok;

  assign head_wr   = q_wr[rd_ptr];
  assign head_size = q_size[rd_ptr];
  assign head_addr = q_addr[rd_ptr];
  assign head_idx  = head_addr[ADDR_W+1:2];

  assign data_data_ok = q_valid[rd_ptr] && (q_cd[rd_ptr] == 4'd0);

  // Byte-lane strobe and misalignment/illegal-size detection for the head.
  always_comb begin
    head_strb = 4'b0000;
    head_bad  = 1'b0;
    case (head_size)
      2'd0: head_strb = 4'b0001 << head_addr[1:0];
      2'd1: begin
        if (head_addr[0]) head_bad = 1'b1;
        else              head_strb = head_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        if (head_addr[1:0] != 2'b00) head_bad = 1'b1;
        else                         head_strb = 4'b1111;
      end
      default: head_bad = 1'b1;
    endcase
  end

  // Completion outputs: error flag and load data only during the pulse.
  always_comb begin
    data_err   = data_data_ok & head_bad;
    data_rdata = 32'h0;
    if (data_data_ok && !head_wr && !head_bad) data_rdata = mem[head_idx];
  end

  // Queue state: countdowns, push on accept, pop on completion; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SLOTS; k++) q_valid[k] <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int k = 0; k < SLOTS; k++) begin
        if (q_valid[k] && (q_cd[k] != 4'd0)) q_cd[k] <= q_cd[k] - 4'd1;
      end
      if (data_data_ok) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= next_ptr(rd_ptr);
      end
      if (accept) begin
        q_valid[wr_ptr] <= 1'b1;
        q_wr[wr_ptr]    <= data_wr;
        q_size[wr_ptr]  <= data_size;
        q_addr[wr_ptr]  <= data_addr[ADDR_W+1:0];
        q_wdata[wr_ptr] <= data_wdata;
        q_cd[wr_ptr]    <= CD_INIT;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      case ({accept, data_data_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Array write: strobed lanes of a completing store; suppressed by reset.
  always_ff @(posedge clk) begin
    if (!rst && data_data_ok && head_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (head_strb[b]) mem[head_idx][8*b +: 8] <= q_wdata[rd_ptr][8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_sram_slave.sv
// Directed bench for dmem_sram_slave. Three instances cover the latency /
// depth combinations: u0 (LATENCY=2), u1 (LATENCY=1), u2 (LATENCY=4), all
// QDEPTH=2. Inputs change and outputs are sampled on the falling edge.
module tb_dmem_sram_slave;

  logic        clk;
  logic        rst;
  logic        req_s   [3];
  logic        wr_s    [3];
  logic [1:0]  size_s  [3];
  logic [31:0] addr_s  [3];
  logic [31:0] wdata_s [3];
  logic        aok_s   [3];
  logic        dok_s   [3];
  logic [31:0] rdata_s [3];
  logic        err_s   [3];

  int n_vec;
  int n_bad;
  logic [31:0] exp_q[$];

  // Clock and global watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  dmem_sram_slave #(.ADDR_W(10), .LATENCY(2), .QDEPTH(2)) u0 (
    .clk(clk), .rst(rst), .data_req(req_s[0]), .data_wr(wr_s[0]),
    .data_size(size_s[0]), .data_addr(addr_s[0]), .data_wdata(wdata_s[0]),
    .data_addr_ok(aok_s[0]), .data_data_ok(dok_s[0]), .data_rdata(rdata_s[0]),
    .data_err(err_s[0]));

  dmem_sram_slave #(.ADDR_W(10), .LATENCY(1), .QDEPTH(2)) u1 (
    .clk(clk), .rst(rst), .data_req(req_s[1]), .data_wr(wr_s[1]),
    .data_size(size_s[1]), .data_addr(addr_s[1]), .data_wdata(wdata_s[1]),
    .data_addr_ok(aok_s[1]), .data_data_ok(dok_s[1]), .data_rdata(rdata_s[1]),
    .data_err(err_s[1]));

  dmem_sram_slave #(.ADDR_W(10), .LATENCY(4), .QDEPTH(2)) u2 (
    .clk(clk), .rst(rst), .data_req(req_s[2]), .data_wr(wr_s[2]),
    .data_size(size_s[2]), .data_addr(addr_s[2]), .data_wdata(wdata_s[2]),
    .data_addr_ok(aok_s[2]), .data_data_ok(dok_s[2]), .data_rdata(rdata_s[2]),
    .data_err(err_s[2]));

  // Driver: set request fields for one instance.
  task automatic drive(input int i, input logic r, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    req_s[i] = r; wr_s[i] = w; size_s[i] = sz; addr_s[i] = a; wdata_s[i] = wd;
  endtask

  // Driver: one request on an idle instance; reports cycles from acceptance
  // to data_ok (-1 on timeout) plus the completion rdata/err.
  task automatic do_req(input int i, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic e);
    int n;
    bit acc;
    bit got;
    lat = -1; rd = 32'h0; e = 1'b0; acc = 0; got = 0; n = 0;
    @(negedge clk);
    drive(i, 1'b1, w, sz, a, wd);
    while (!acc && n < 20) begin
      if (aok_s[i]) acc = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (acc) begin
      @(negedge clk);
      drive(i, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      n = 1;
      while (!got && n <= 20) begin
        if (dok_s[i]) begin
          got = 1; lat = n; rd = rdata_s[i]; e = err_s[i];
        end else begin
          @(negedge clk);
          n++;
        end
      end
    end else begin
      drive(i, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (aok_s[i] !== 1'b1) begin n_bad++; $display("FAIL rst_addr_ok[%0d] got %b exp 1", i, aok_s[i]); end
      n_vec++; if (dok_s[i] !== 1'b0) begin n_bad++; $display("FAIL rst_data_ok[%0d] got %b exp 0", i, dok_s[i]); end
      n_vec++; if (rdata_s[i] !== 32'h0) begin n_bad++; $display("FAIL rst_rdata[%0d] got %h exp 0", i, rdata_s[i]); end
      n_vec++; if (err_s[i] !== 1'b0) begin n_bad++; $display("FAIL rst_err[%0d] got %b exp 0", i, err_s[i]); end
    end
  endtask

  task automatic test_word;
    int lat; logic [31:0] rd; logic e;
    do_req(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, lat, rd, e);
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL word_st_lat got %0d exp 2", lat); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL word_st_err got %b exp 0", e); end
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL word_st_rdata got %h exp 0", rd); end
    do_req(0, 1'b0, 2'd2, 32'h10, 32'h0, lat, rd, e);
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL word_ld_lat got %0d exp 2", lat); end
    n_vec++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_ld_rdata got %h exp deadbeef", rd); end
  endtask

  task automatic test_lanes;
    int lat; logic [31:0] rd; logic e;
    do_req(0, 1'b1, 2'd0, 32'h11, 32'h0000AA00, lat, rd, e);
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL byte_st_err got %b exp 0", e); end
    do_req(0, 1'b1, 2'd1, 32'h12, 32'h12340000, lat, rd, e);
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL half_st_err got %b exp 0", e); end
    do_req(0, 1'b0, 2'd2, 32'h10, 32'h0, lat, rd, e);
    n_vec++; if (rd !== 32'h1234AAEF) begin n_bad++; $display("FAIL lanes_ld_rdata got %h exp 1234aaef", rd); end
    // Upper address bits alias onto the same word.
    do_req(0, 1'b0, 2'd2, 32'h8000_1010, 32'h0, lat, rd, e);
    n_vec++; if (rd !== 32'h1234AAEF) begin n_bad++; $display("FAIL alias_ld_rdata got %h exp 1234aaef", rd); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] rd; logic e;
    logic [31:0] exp_d;
    for (int k = 0; k < 8; k++)
      do_req(1, 1'b1, 2'd2, 32'h100 + 32'(4*k), 32'hA500_0000 + 32'(k * 17), lat, rd, e);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 8) begin
        drive(1, 1'b1, 1'b0, 2'd2, 32'h100 + 32'(4*c), 32'h0);
        exp_q.push_back(32'hA500_0000 + 32'(c * 17));
        n_vec++; if (aok_s[1] !== 1'b1) begin n_bad++; $display("FAIL b2b_addr_ok c%0d got %b exp 1", c, aok_s[1]); end
      end else begin
        drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      end
      n_vec++;
      if (dok_s[1] !== ((c >= 1) && (c <= 8))) begin
        n_bad++; $display("FAIL b2b_data_ok c%0d got %b exp %b", c, dok_s[1], (c >= 1) && (c <= 8));
      end
      if (dok_s[1] === 1'b1 && exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        n_vec++; if (rdata_s[1] !== exp_d) begin n_bad++; $display("FAIL b2b_rdata c%0d got %h exp %h", c, rdata_s[1], exp_d); end
      end
    end
    // Store immediately followed by a load of the same word.
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 2'd2, 32'h100, 32'hCAFEF00D);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
    n_vec++; if (dok_s[1] !== 1'b1 || err_s[1] !== 1'b0) begin n_bad++; $display("FAIL raw_st_done got ok=%b err=%b exp ok=1 err=0", dok_s[1], err_s[1]); end
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    n_vec++; if (dok_s[1] !== 1'b1) begin n_bad++; $display("FAIL raw_ld_ok got %b exp 1", dok_s[1]); end
    n_vec++; if (rdata_s[1] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL raw_ld_rdata got %h exp cafef00d", rdata_s[1]); end
    @(negedge clk);
    n_vec++; if (dok_s[1] !== 1'b0) begin n_bad++; $display("FAIL raw_idle_ok got %b exp 0", dok_s[1]); end
  endtask

  task automatic test_full_queue;
    logic exp_aok;
    logic exp_dok;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c <= 5) drive(2, 1'b1, 1'b0, 2'd2, 32'h0, 32'h0);
      else        drive(2, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      exp_aok = !((c >= 2) && (c <= 4));
      exp_dok = (c == 4) || (c == 5) || (c == 9);
      n_vec++; if (aok_s[2] !== exp_aok) begin n_bad++; $display("FAIL full_addr_ok c%0d got %b exp %b", c, aok_s[2], exp_aok); end
      n_vec++; if (dok_s[2] !== exp_dok) begin n_bad++; $display("FAIL full_data_ok c%0d got %b exp %b", c, dok_s[2], exp_dok); end
    end
  endtask

  task automatic test_misaligned;
    int lat; logic [31:0] rd; logic e;
    do_req(0, 1'b1, 2'd2, 32'h20, 32'h01020304, lat, rd, e);
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL mis_setup_err got %b exp 0", e); end
    do_req(0, 1'b1, 2'd2, 32'h22, 32'hFFFFFFFF, lat, rd, e);
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL mis_word_lat got %0d exp 2", lat); end
    n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL mis_word_err got %b exp 1", e); end
    do_req(0, 1'b1, 2'd1, 32'h21, 32'hFFFFFFFF, lat, rd, e);
    n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL mis_half_err got %b exp 1", e); end
    do_req(0, 1'b0, 2'd2, 32'h20, 32'h0, lat, rd, e);
    n_vec++; if (rd !== 32'h01020304) begin n_bad++; $display("FAIL mis_unchanged got %h exp 01020304", rd); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL mis_ld_err got %b exp 0", e); end
    do_req(0, 1'b0, 2'd3, 32'h20, 32'h0, lat, rd, e);
    n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL size3_err got %b exp 1", e); end
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL size3_rdata got %h exp 0", rd); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic e;
    do_req(0, 1'b1, 2'd2, 32'h40, 32'h11111111, lat, rd, e);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 2'd2, 32'h40, 32'h55555555);
    n_vec++; if (aok_s[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_accept got %b exp 1", aok_s[0]); end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    rst = 1'b1;
    n_vec++; if (dok_s[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_early_ok got %b exp 0", dok_s[0]); end
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (dok_s[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_data_ok got %b exp 0", dok_s[0]); end
    n_vec++; if (aok_s[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_addr_ok got %b exp 1", aok_s[0]); end
    n_vec++; if (rdata_s[0] !== 32'h0) begin n_bad++; $display("FAIL rmid_rdata got %h exp 0", rdata_s[0]); end
    n_vec++; if (err_s[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_err got %b exp 0", err_s[0]); end
    @(negedge clk);
    n_vec++; if (dok_s[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_late_ok got %b exp 0", dok_s[0]); end
    do_req(0, 1'b0, 2'd2, 32'h40, 32'h0, lat, rd, e);
    n_vec++; if (rd !== 32'h11111111) begin n_bad++; $display("FAIL rmid_old_data got %h exp 11111111", rd); end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    test_reset();
    test_word();
    test_lanes();
    test_back_to_back();
    test_full_queue();
    test_misaligned();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
